// File: rtl/interrupt_arbiter.sv
// Interrupt request front end: pin synchronisers, NMI edge latch, IRQ masking and RES/BRK/NMI/IRQ arbitration.
// Optional build macro INT_NMI_HIJACK_EN lets a pending NMI take over an unlocked IRQ/BRK grant.
module interrupt_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_x,
  input  logic        nmi_x,
  input  logic        psr_i,
  input  logic        brk,
  input  logic        insn_end,
  input  logic        vec_lock,
  input  logic        int_ack,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] int_vec,
  output logic        int_b,
  output logic        nmi_pending
);

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'b00,
    ST_IDLE     = 2'b01,
    ST_GRANT    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    KIND_RES = 2'b00,
    KIND_NMI = 2'b01,
    KIND_IRQ = 2'b10,
    KIND_BRK = 2'b11
  } kind_t;

  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  function automatic logic [15:0] vec_of(input kind_t kind);
    case (kind)
      KIND_RES: vec_of = VEC_RES;
      KIND_NMI: vec_of = VEC_NMI;
      default:  vec_of = VEC_IRQ;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] irq_sync_q, nmi_sync_q;
  logic                   nmi_prev_q;
  logic                   nmi_pending_q, nmi_pending_d;
  state_t                 state_q, state_d;
  kind_t                  kind_q, kind_d;
  logic [15:0]            vec_q, vec_d;
  logic                   b_q, b_d;
  logic                   locked_q, locked_d;

  logic irq_s, nmi_s, nmi_fall, nmi_clr, irq_qual;

  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev_q & ~nmi_s;
  assign nmi_clr  = (state_q == ST_GRANT) & vec_lock & (kind_q == KIND_NMI);
  assign irq_qual = ~irq_s & ~psr_i;

  // A new edge in the same cycle as the consuming vec_lock must not be lost.
  assign nmi_pending_d = nmi_fall | (nmi_pending_q & ~nmi_clr);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    kind_d   = kind_q;
    vec_d    = vec_q;
    b_d      = b_q;
    locked_d = locked_q;
    case (state_q)
      ST_RST_WAIT: begin
        state_d = ST_GRANT;
        kind_d  = KIND_RES;
        vec_d   = VEC_RES;
        b_d     = 1'b0;
      end
      ST_IDLE: begin
        if (brk) begin
          state_d = ST_GRANT;
          kind_d  = KIND_BRK;
          vec_d   = vec_of(KIND_BRK);
          b_d     = 1'b1;
        end else if (insn_end && nmi_pending_q) begin
          state_d = ST_GRANT;
          kind_d  = KIND_NMI;
          vec_d   = vec_of(KIND_NMI);
          b_d     = 1'b0;
        end else if (insn_end && irq_qual) begin
          state_d = ST_GRANT;
          kind_d  = KIND_IRQ;
          vec_d   = vec_of(KIND_IRQ);
          b_d     = 1'b0;
        end
      end
      ST_GRANT: begin
        if (int_ack) begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end else begin
          if (vec_lock) locked_d = 1'b1;
`ifdef INT_NMI_HIJACK_EN
          // Hijack keeps b_q so a BRK taken over by NMI still pushes B=1.
          if (!locked_q && nmi_pending_q && (kind_q == KIND_IRQ || kind_q == KIND_BRK)) begin
            kind_d = KIND_NMI;
            vec_d  = VEC_NMI;
          end
`endif
        end
      end
      default: state_d = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_sync_q    <= '1;
      nmi_sync_q    <= '1;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      state_q       <= ST_RST_WAIT;
      kind_q        <= KIND_RES;
      vec_q         <= VEC_RES;
      b_q           <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
      irq_sync_q    <= {irq_sync_q[SYNC_STAGES-2:0], irq_x};
      nmi_sync_q    <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_x};
      nmi_prev_q    <= nmi_s;
      nmi_pending_q <= nmi_pending_d;
      state_q       <= state_d;
      kind_q        <= kind_d;
      vec_q         <= vec_d;
      b_q           <= b_d;
      locked_q      <= locked_d;
    end
  end

  assign int_req     = (state_q == ST_GRANT);
  assign int_kind    = kind_q;
  assign int_vec     = vec_q;
  assign int_b       = b_q;
  assign nmi_pending = nmi_pending_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: vector table, directed corner sequences, random run against a model.
module tb_interrupt_arbiter;
  localparam int SYNC_STAGES = 2;

  logic        clk, rst, irq_x, nmi_x, psr_i, brk, insn_end, vec_lock, int_ack;
  logic        int_req, int_b, nmi_pending;
  logic [1:0]  int_kind;
  logic [15:0] int_vec;

  interrupt_arbiter #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .irq_x(irq_x), .nmi_x(nmi_x), .psr_i(psr_i),
    .brk(brk), .insn_end(insn_end), .vec_lock(vec_lock), .int_ack(int_ack),
    .int_req(int_req), .int_kind(int_kind), .int_vec(int_vec), .int_b(int_b),
    .nmi_pending(nmi_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INT_NMI_HIJACK_EN
  localparam bit HIJACK = 1'b1;
`else
  localparam bit HIJACK = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Request-level view: a pin is seen SYNC_STAGES edges late, NMI is a sticky flag,
  // and at most one outstanding request exists.
  bit         m_en = 1'b0;
  bit         m_irq_hist[$], m_nmi_hist[$];
  bit         m_nmi_last, m_pend, m_started, m_busy, m_locked, m_b;
  logic [1:0] m_kind;

  function automatic logic [15:0] vec_of(input logic [1:0] k);
    return (k == 2'd0) ? 16'hFFFC : (k == 2'd1) ? 16'hFFFA : 16'hFFFE;
  endfunction

  task automatic model_reset();
    m_irq_hist.delete();
    m_nmi_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_irq_hist.push_back(1'b1);
      m_nmi_hist.push_back(1'b1);
    end
    m_nmi_last = 1'b1; m_pend = 1'b0; m_started = 1'b0;
    m_busy = 1'b0; m_locked = 1'b0; m_b = 1'b0; m_kind = 2'd0;
  endtask

  task automatic model_step();
    bit irq_seen, nmi_seen, fall, pend_old, clear;
    if (rst) begin
      model_reset();
      return;
    end
    irq_seen = m_irq_hist.pop_front(); m_irq_hist.push_back(irq_x);
    nmi_seen = m_nmi_hist.pop_front(); m_nmi_hist.push_back(nmi_x);
    fall       = m_nmi_last && !nmi_seen;
    m_nmi_last = nmi_seen;
    pend_old   = m_pend;
    clear      = m_busy && vec_lock && (m_kind == 2'd1);
    if (!m_started) begin
      m_started = 1'b1; m_busy = 1'b1; m_kind = 2'd0; m_b = 1'b0;
    end else if (m_busy) begin
      if (int_ack) begin
        m_busy = 1'b0; m_locked = 1'b0;
      end else begin
        if (HIJACK && !m_locked && pend_old && m_kind >= 2'd2) m_kind = 2'd1;
        if (vec_lock) m_locked = 1'b1;
      end
    end else if (brk) begin
      m_busy = 1'b1; m_kind = 2'd3; m_b = 1'b1;
    end else if (insn_end && pend_old) begin
      m_busy = 1'b1; m_kind = 2'd1; m_b = 1'b0;
    end else if (insn_end && !irq_seen && !psr_i) begin
      m_busy = 1'b1; m_kind = 2'd2; m_b = 1'b0;
    end
    m_pend = fall || (pend_old && !clear);
  endtask

  task automatic compare_model();
    check("rnd_req", int_req, m_busy);
    if (m_busy) begin
      check("rnd_kind", int_kind, m_kind);
      check("rnd_vec", int_vec, vec_of(m_kind));
      check("rnd_b", int_b, m_b);
    end
    check("rnd_pend", nmi_pending, m_pend);
  endtask

  // Inputs change only #1 after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    if (m_en) model_step();
    #1;
  endtask

  task automatic clr_pulses();
    brk = 1'b0; insn_end = 1'b0; vec_lock = 1'b0; int_ack = 1'b0;
  endtask

  task automatic check_grant(input string name, input logic [1:0] kind, input logic b);
    check({name, "_req"}, int_req, 1'b1);
    check({name, "_kind"}, int_kind, kind);
    check({name, "_vec"}, int_vec, vec_of(kind));
    check({name, "_b"}, int_b, b);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, irq_x, nmi_x, psr, brk, ie, vl, ack;
    logic       exp_req;
    logic [1:0] exp_kind;
    logic       exp_b, exp_pend;
  } vec_t;

  vec_t tbl[9];
  int   nmi_grants;
  logic prev_req;

  initial begin
    //          rst irq nmi psr brk ie  vl  ack  req kind  b  pend
    tbl[0] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'd0, 1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0, 1'b0,1'b0};
    tbl[2] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0, 1'b0,1'b0};
    tbl[3] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0, 1'b0,1'b0};
    tbl[4] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0, 1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,2'd2, 1'b0,1'b0};
    tbl[6] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,2'd2, 1'b0,1'b0};
    tbl[7] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'd2, 1'b0,1'b0};
    tbl[8] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0, 1'b0,1'b0};

    rst = 1'b1; irq_x = 1'b1; nmi_x = 1'b1; psr_i = 1'b1;
    clr_pulses();
    tick(); tick();
    check("rst_req", int_req, 1'b0);
    check("rst_kind", int_kind, 2'b00);
    check("rst_vec", int_vec, 16'hFFFC);
    check("rst_b", int_b, 1'b0);
    check("rst_pend", nmi_pending, 1'b0);

    // Reset release, ack, IRQ masking then an unmasked IRQ grant.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; irq_x = tbl[i].irq_x; nmi_x = tbl[i].nmi_x; psr_i = tbl[i].psr;
      brk = tbl[i].brk; insn_end = tbl[i].ie; vec_lock = tbl[i].vl; int_ack = tbl[i].ack;
      tick();
      check($sformatf("tbl%0d_req", i), int_req, tbl[i].exp_req);
      if (tbl[i].exp_req) begin
        check($sformatf("tbl%0d_kind", i), int_kind, tbl[i].exp_kind);
        check($sformatf("tbl%0d_vec", i), int_vec, vec_of(tbl[i].exp_kind));
        check($sformatf("tbl%0d_b", i), int_b, tbl[i].exp_b);
      end
      check($sformatf("tbl%0d_pend", i), nmi_pending, tbl[i].exp_pend);
    end
    clr_pulses();

    // NMI edge: pending appears SYNC_STAGES+1 edges after the pin falls.
    nmi_x = 1'b0; tick();
    check("nmi_pend_e1", nmi_pending, 1'b0);
    tick();
    check("nmi_pend_e2", nmi_pending, 1'b0);
    nmi_x = 1'b1; tick();
    check("nmi_pend_e3", nmi_pending, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("nmi_wait_req", int_req, 1'b0);
    insn_end = 1'b1; tick(); clr_pulses();
    check_grant("nmi_grant", 2'd1, 1'b0);
    check("nmi_pend_held", nmi_pending, 1'b1);
    vec_lock = 1'b1; tick(); clr_pulses();
    check("nmi_lock_pend", nmi_pending, 1'b0);
    check("nmi_lock_req", int_req, 1'b1);
    int_ack = 1'b1; tick(); clr_pulses();
    check("nmi_ack_req", int_req, 1'b0);

    // A long low NMI level is a single edge: exactly one grant.
    nmi_grants = 0; prev_req = 1'b0; nmi_x = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) nmi_x = 1'b1;
      insn_end = 1'b1; vec_lock = int_req; int_ack = int_req;
      tick();
      if (int_req && !prev_req) nmi_grants++;
      prev_req = int_req;
    end
    clr_pulses(); tick();
    check("nmi_level_grants", nmi_grants, 1);
    check("nmi_level_pend", nmi_pending, 1'b0);
    check("nmi_level_req", int_req, 1'b0);

    // Priority: BRK beats a pending NMI and a qualified IRQ in the same cycle.
    nmi_x = 1'b0; tick(); tick(); tick(); nmi_x = 1'b1;
    irq_x = 1'b0; psr_i = 1'b0; tick(); tick();
    check("pri_pend", nmi_pending, 1'b1);
    check("pri_idle", int_req, 1'b0);
    brk = 1'b1; insn_end = 1'b1; tick(); clr_pulses();
    check_grant("pri_brk", 2'd3, 1'b1);
    check("pri_brk_pend", nmi_pending, 1'b1);
    tick();
    check_grant("pri_after", HIJACK ? 2'd1 : 2'd3, 1'b1);
    vec_lock = 1'b1; tick(); clr_pulses();
    check("pri_lock_pend", nmi_pending, !HIJACK);
    int_ack = 1'b1; tick(); clr_pulses();
    check("pri_ack_req", int_req, 1'b0);
    insn_end = 1'b1; tick(); clr_pulses();
    check_grant("pri_next", HIJACK ? 2'd2 : 2'd1, 1'b0);
    vec_lock = 1'b1; tick(); clr_pulses();
    int_ack = 1'b1; irq_x = 1'b1; tick(); clr_pulses();
    check("pri_end_pend", nmi_pending, 1'b0);
    tick(); tick();

    // NMI edge arrives during an unlocked BRK grant.
    brk = 1'b1; tick(); clr_pulses();
    check_grant("hj_brk", 2'd3, 1'b1);
    nmi_x = 1'b0; tick(); tick(); nmi_x = 1'b1; tick();
    check("hj_pend", nmi_pending, 1'b1);
    tick();
    check_grant("hj_kind", HIJACK ? 2'd1 : 2'd3, 1'b1);
    vec_lock = 1'b1; tick(); clr_pulses();
    check("hj_lock_pend", nmi_pending, !HIJACK);
    int_ack = 1'b1; tick(); clr_pulses();
    insn_end = 1'b1; tick(); clr_pulses();
    check("hj_next_req", int_req, !HIJACK);
    if (int_req) check("hj_next_kind", int_kind, 2'd1);
    vec_lock = int_req; tick(); clr_pulses();
    int_ack = int_req; tick(); clr_pulses();
    check("hj_done_pend", nmi_pending, 1'b0);

    // Asynchronous reset in the middle of an IRQ grant with NMI pending.
    irq_x = 1'b0; tick(); tick();
    insn_end = 1'b1; tick(); clr_pulses();
    check_grant("mid_irq", 2'd2, 1'b0);
    nmi_x = 1'b0; tick(); tick(); tick();
    check("mid_pend", nmi_pending, 1'b1);
    rst = 1'b1; #1;
    check("mid_rst_req", int_req, 1'b0);
    check("mid_rst_kind", int_kind, 2'b00);
    check("mid_rst_vec", int_vec, 16'hFFFC);
    check("mid_rst_b", int_b, 1'b0);
    check("mid_rst_pend", nmi_pending, 1'b0);
    nmi_x = 1'b1; irq_x = 1'b1; tick();
    rst = 1'b0; tick();
    check_grant("mid_res", 2'd0, 1'b0);

    // Random phase against the model.
    rst = 1'b1; clr_pulses(); irq_x = 1'b1; nmi_x = 1'b1; psr_i = 1'b1;
    m_en = 1'b1; model_reset(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(499) == 0);
      if ($urandom_range(9) == 0) irq_x = ~irq_x;
      if ($urandom_range(7) == 0) nmi_x = ~nmi_x;
      if ($urandom_range(9) == 0) psr_i = ~psr_i;
      brk      = ($urandom_range(19) == 0);
      insn_end = ($urandom_range(9) < 3);
      vec_lock = ($urandom_range(3) == 0);
      int_ack  = ($urandom_range(4) == 0);
      tick();
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Upstream front end of the interrupt handler. Synchronises the asynchronous `irq_x`/`nmi_x` pins, edge-detects and latches NMI, gates IRQ with the I flag and arbitrates reset, NMI, BRK and IRQ. It issues one request at a time (kind, vector, pushed B-flag value) to the interrupt handler and holds it until the handler acknowledges.

## Interface
- `SYNC_STAGES`, default 2, flop stages on `irq_x`/`nmi_x` synchronisers; legal values 2..3.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `irq_x`  in  1  IRQ pin, active-low, level-sensitive, asynchronous.
- `nmi_x`  in  1  NMI pin, active-low, falling-edge-sensitive, asynchronous.
- `psr_i`  in  1  I flag from the register file; 1 masks IRQ.
- `brk`  in  1  one-cycle pulse from the decoder when a BRK opcode is fetched.
- `insn_end`  in  1  one-cycle pulse at each instruction boundary.
- `vec_lock`  in  1  one-cycle pulse from the handler when it starts the vector low-byte read.
- `int_ack`  in  1  one-cycle pulse from the handler when the sequence is complete.
- `int_req`  out  1  request valid.
- `int_kind`  out  2  00 RES, 01 NMI, 10 IRQ, 11 BRK.
- `int_vec`  out  16  vector low-byte address: RES `$FFFC`, NMI `$FFFA`, IRQ/BRK `$FFFE`.
- `int_b`  out  1  B-flag value to push: 1 for BRK, else 0.
- `nmi_pending`  out  1  NMI edge latched and not yet consumed.

## Operation
- Synchronisers: `irq_s`/`nmi_s` are the `SYNC_STAGES`-deep resynchronised pins. Both reset to 1 (inactive).
- NMI edge: `nmi_s` changes 1→0 (previous value registered) → set `nmi_pending`. It is cleared on `vec_lock` while the granted kind is NMI. If a set and a clear happen in the same cycle, the set wins.
- IRQ is not latched. It qualifies only when `irq_s`=0 and `psr_i`=0 in the `insn_end` cycle.
- FSM states:
  - RST_WAIT (reset state) → GRANT with RES on the first edge after `rst` falls.
  - IDLE → GRANT when any of the following holds:
    - `brk`=1 → BRK (any cycle, also wins over a concurrent `insn_end`).
    - `insn_end`=1 and `nmi_pending` → NMI.
    - `insn_end`=1 and IRQ qualified → IRQ.
    - Priority: BRK > NMI > IRQ. An NMI that loses stays pending.
  - GRANT: `int_req`=1 with kind, vector and `int_b` driven from registers. `vec_lock` sets an internal `locked` bit. `int_ack` → IDLE and clears `locked`.
  - LOCKED-free GRANT: kind may change only through the hijack feature (see Configuration).
- `int_ack` or `vec_lock` received in IDLE or RST_WAIT is ignored. `brk`/`insn_end` received in GRANT is ignored; the `brk` is lost and the decoder must not issue one.
- `rst` in any state: state immediately goes to RST_WAIT and `nmi_pending`, `locked` and the synchronisers are cleared.

## Timing
- Reset values: `int_req`=0, `int_kind`=00, `int_vec`=`$FFFC`, `int_b`=0, `nmi_pending`=0.
- First edge after `rst` deasserts → `int_req`=1, RES, `$FFFC`.
- Pin → `irq_s`/`nmi_s`: `SYNC_STAGES` edges.
- `nmi_s` fall → `nmi_pending`=1: +1 edge.
- `insn_end`/`brk` sampled at edge N → `int_req`, `int_kind`, `int_vec` valid after edge N (registered, 1-cycle latency).
- `int_ack` at edge N → `int_req`=0 after edge N. A new request can be granted no earlier than edge N+1.
- Outputs are stable from the grant edge until `int_ack`, except for a hijack.

## Configuration
- `INT_NMI_HIJACK_EN` defined: in GRANT with kind IRQ or BRK and `locked`=0, a set `nmi_pending` switches kind to NMI and vector to `$FFFA` on the next edge. `int_b` is kept: 1 if the original kind was BRK. `nmi_pending` is then consumed on `vec_lock`.
- `INT_NMI_HIJACK_EN` undefined: the granted kind never changes. The NMI stays pending and is taken at the first `insn_end` after returning to IDLE.

## Test plan
- Reset release: `rst` 1→0 → next edge `int_req`=1, `int_kind`=00, `int_vec`=`$FFFC`. `int_ack` → `int_req`=0.
- NMI edge: `nmi_x` low for 2 cycles, then high; `insn_end` 6 cycles later → `nmi_pending`=1 after `SYNC_STAGES`+1 edges, then a grant of 01/`$FFFA`. `vec_lock` → `nmi_pending`=0. Holding `nmi_x` low for 20 cycles yields exactly one NMI.
- IRQ masking: `irq_x`=0, `psr_i`=1, `insn_end` pulses → no request. `psr_i`=0 plus `insn_end` → grant 10/`$FFFE`, `int_b`=0.
- Priority: `brk`+`insn_end` with `nmi_pending`=1 and IRQ qualified → BRK granted (11, `$FFFE`, `int_b`=1) and NMI still pending. After `int_ack`, the next `insn_end` → NMI.
- Hijack: NMI edge during a BRK grant before `vec_lock` → with `INT_NMI_HIJACK_EN`, `int_kind`=01, `int_vec`=`$FFFA`, `int_b`=1. Without it, no change, and NMI is taken after `int_ack` plus `insn_end`.
- Reset mid-grant: assert `rst` during an IRQ grant → outputs return to reset values asynchronously and `nmi_pending`=0. Release → RES request.
